scroll_lane_bank: RTL and testbench

- Parametrised bank of independent horizontal scroll followers, one per obstacle lane (cars, logs) of the crossy-road playfield.
- Per lane: position, direction, step size and speed divider, plus a choice of wrap-around or bounce at the screen edges.
- Driven by the shared frame-rate move tick; position outputs feed the obstacle sprite renderers.
- Adds per-lane speed division, bidirectional motion, modular wrap, bounce mode, freeze and edge-event pulses.

---
 rtl/scroll_lane_bank.sv | 119 +++++++++++
 tb/tb_scroll_lane_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scroll_lane_bank.sv
// Bank of independent horizontal scroll followers, one per obstacle lane.
// Each lane steps on a divided move tick and either wraps or bounces at the screen edges.
module scroll_lane_bank #(
  parameter int LANES  = 4,
  parameter int POS_W  = 10,
  parameter int SPAN   = 640,
  parameter int STEP_W = 3,
  parameter int DIV_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [LANES*POS_W-1:0]    start_pos,
  input  logic [LANES-1:0]          cfg_dir,
  input  logic [LANES*STEP_W-1:0]   cfg_step,
  input  logic [LANES*DIV_W-1:0]    cfg_div,
  input  logic [LANES-1:0]          cfg_bounce,
  input  logic                      move,
  input  logic                      freeze,
  output logic [LANES*POS_W-1:0]    pos,
  output logic [LANES-1:0]          dir_state,
  output logic [LANES-1:0]          edge_pulse
);

  // Arithmetic runs one bit wider so pos+step never overflows before the edge test.
  localparam logic [POS_W:0]   SPAN_X = (POS_W+1)'(SPAN);
  localparam logic [POS_W-1:0] LAST   = POS_W'(SPAN - 1);

  logic tick;
  assign tick = move & ~freeze & ~load;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [POS_W-1:0] pos_q;
    logic             dir_q;
    logic             edge_q;
    logic [DIV_W-1:0] cnt_q;

    logic [POS_W:0]   cur;
    logic [POS_W:0]   step_x;
    logic [POS_W:0]   sum;
    logic [POS_W-1:0] nxt;
    logic             nxt_dir;
    logic             hit;
    logic [POS_W-1:0] load_val;
    logic             div_hit;

    assign div_hit = (cnt_q == cfg_div[g*DIV_W +: DIV_W]);

    always_comb begin
      cur      = {1'b0, pos_q};
      step_x   = (POS_W+1)'(cfg_step[g*STEP_W +: STEP_W]);
      sum      = cur + step_x;
      nxt      = pos_q;
      nxt_dir  = dir_q;
      hit      = 1'b0;
      load_val = start_pos[g*POS_W +: POS_W];
      if ({1'b0, start_pos[g*POS_W +: POS_W]} >= SPAN_X) begin
        load_val = LAST;
      end
      if (!dir_q) begin
        if (sum < SPAN_X) begin
          nxt = POS_W'(sum);
        end else begin
          hit = 1'b1;
          if (cfg_bounce[g]) begin
            nxt     = LAST;
            nxt_dir = 1'b1;
          end else begin
            nxt = POS_W'(sum - SPAN_X);
          end
        end
      end else begin
        if (cur >= step_x) begin
          nxt = POS_W'(cur - step_x);
        end else begin
          hit = 1'b1;
          if (cfg_bounce[g]) begin
            nxt     = '0;
            nxt_dir = 1'b0;
          end else begin
            nxt = POS_W'(cur + SPAN_X - step_x);
          end
        end
      end
    end

    // A lowered divider is not clamped: the counter keeps counting until it wraps to match.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_q  <= '0;
        dir_q  <= 1'b0;
        edge_q <= 1'b0;
        cnt_q  <= '0;
      end else if (load) begin
        pos_q  <= load_val;
        dir_q  <= cfg_dir[g];
        edge_q <= 1'b0;
        cnt_q  <= '0;
      end else if (tick) begin
        if (!div_hit) begin
          cnt_q  <= cnt_q + 1'b1;
          edge_q <= 1'b0;
        end else begin
          cnt_q  <= '0;
          pos_q  <= nxt;
          dir_q  <= nxt_dir;
          edge_q <= hit;
        end
      end else begin
        edge_q <= 1'b0;
      end
    end

    assign pos[g*POS_W +: POS_W] = pos_q;
    assign dir_state[g]          = dir_q;
    assign edge_pulse[g]         = edge_q;
  end

endmodule

// File: tb/tb_scroll_lane_bank.sv
// Directed bench for scroll_lane_bank: a table of per-cycle vectors plus hand sequences
// for multi-lane edge events and asynchronous reset.
module tb_scroll_lane_bank;

  localparam int LANES  = 4;
  localparam int POS_W  = 10;
  localparam int SPAN   = 640;
  localparam int STEP_W = 3;
  localparam int DIV_W  = 2;
  localparam int W      = LANES*POS_W + 2*LANES;

  logic                    clk;
  logic                    rst_n;
  logic                    load;
  logic [LANES*POS_W-1:0]  start_pos;
  logic [LANES-1:0]        cfg_dir;
  logic [LANES*STEP_W-1:0] cfg_step;
  logic [LANES*DIV_W-1:0]  cfg_div;
  logic [LANES-1:0]        cfg_bounce;
  logic                    move;
  logic                    freeze;
  logic [LANES*POS_W-1:0]  pos;
  logic [LANES-1:0]        dir_state;
  logic [LANES-1:0]        edge_pulse;

  scroll_lane_bank #(
    .LANES(LANES), .POS_W(POS_W), .SPAN(SPAN), .STEP_W(STEP_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start_pos(start_pos),
    .cfg_dir(cfg_dir), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .cfg_bounce(cfg_bounce), .move(move), .freeze(freeze),
    .pos(pos), .dir_state(dir_state), .edge_pulse(edge_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    lane;
    bit    ld, mv, frz;
    int    st, dr, stp, dv, bn;
    int    ep, ed, ee;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic void add(string nm, int lane, bit ld, bit mv, bit frz,
                              int st, int dr, int stp, int dv, int bn,
                              int ep, int ed, int ee);
    vec_t v;
    v.nm = nm; v.lane = lane; v.ld = ld; v.mv = mv; v.frz = frz;
    v.st = st; v.dr = dr; v.stp = stp; v.dv = dv; v.bn = bn;
    v.ep = ep; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [LANES*POS_W-1:0] act, logic [LANES*POS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm, logic [W-1:0] e);
    check({nm, "_pos"}, pos, e[W-1 -: LANES*POS_W]);
    check({nm, "_dir"}, (LANES*POS_W)'(dir_state), (LANES*POS_W)'(e[2*LANES-1 -: LANES]));
    check({nm, "_edge"}, (LANES*POS_W)'(edge_pulse), (LANES*POS_W)'(e[LANES-1:0]));
  endtask

  // driver
  task automatic idle_inputs();
    load = 1'b0; move = 1'b0; freeze = 1'b0;
    start_pos = '0; cfg_dir = '0; cfg_step = '0; cfg_div = '0; cfg_bounce = '0;
  endtask

  task automatic drive(vec_t v);
    idle_inputs();
    load = v.ld; move = v.mv; freeze = v.frz;
    start_pos[v.lane*POS_W +: POS_W]  = POS_W'(v.st);
    cfg_dir[v.lane]                   = v.dr[0];
    cfg_step[v.lane*STEP_W +: STEP_W] = STEP_W'(v.stp);
    cfg_div[v.lane*DIV_W +: DIV_W]    = DIV_W'(v.dv);
    cfg_bounce[v.lane]                = v.bn[0];
  endtask

  function automatic logic [W-1:0] expect_word(vec_t v);
    logic [LANES*POS_W-1:0] p;
    logic [LANES-1:0]       d;
    logic [LANES-1:0]       e;
    p = '0; d = '0; e = '0;
    p[v.lane*POS_W +: POS_W] = POS_W'(v.ep);
    d[v.lane] = v.ed[0];
    e[v.lane] = v.ee[0];
    return {p, d, e};
  endfunction

  initial begin
    // lane0: plain right motion
    add("a_load", 0, 1, 0, 0, 100, 0, 2, 0, 0, 100, 0, 0);
    for (int k = 1; k <= 5; k++)
      add("a_tick", 0, 0, 1, 0, 100, 0, 2, 0, 0, 100 + 2*k, 0, 0);
    // lane1: right wrap keeps the remainder
    add("b_load", 1, 1, 0, 0, 638, 0, 3, 0, 0, 638, 0, 0);
    add("b_wrap", 1, 0, 1, 0, 638, 0, 3, 0, 0, 1, 0, 1);
    add("b_next", 1, 0, 1, 0, 638, 0, 3, 0, 0, 4, 0, 0);
    // lane2: bounce at both edges
    add("c_load",    2, 1, 0, 0, 2,   1, 5, 0, 1, 2,   1, 0);
    add("c_bnc_lo",  2, 0, 1, 0, 2,   1, 5, 0, 1, 0,   0, 1);
    add("c_next",    2, 0, 1, 0, 2,   1, 5, 0, 1, 5,   0, 0);
    add("c_load2",   2, 1, 0, 0, 637, 0, 5, 0, 1, 637, 0, 0);
    add("c_bnc_hi",  2, 0, 1, 0, 637, 0, 5, 0, 1, 639, 1, 1);
    add("c_back",    2, 0, 1, 0, 637, 0, 5, 0, 1, 634, 1, 0);
    // lane3: divide by 3 with a freeze window after the fourth tick
    add("d_load", 3, 1, 0, 0, 10, 0, 1, 2, 0, 10, 0, 0);
    add("d_t1",   3, 0, 1, 0, 10, 0, 1, 2, 0, 10, 0, 0);
    add("d_t2",   3, 0, 1, 0, 10, 0, 1, 2, 0, 10, 0, 0);
    add("d_t3",   3, 0, 1, 0, 10, 0, 1, 2, 0, 11, 0, 0);
    add("d_t4",   3, 0, 1, 0, 10, 0, 1, 2, 0, 11, 0, 0);
    for (int k = 0; k < 4; k++)
      add("d_frz", 3, 0, 1, 1, 10, 0, 1, 2, 0, 11, 0, 0);
    add("d_t5",   3, 0, 1, 0, 10, 0, 1, 2, 0, 11, 0, 0);
    add("d_t6",   3, 0, 1, 0, 10, 0, 1, 2, 0, 12, 0, 0);
    add("d_t7",   3, 0, 1, 0, 10, 0, 1, 2, 0, 12, 0, 0);
    // lane0: load beats move, out-of-range start clamps
    add("e_ldmv", 0, 1, 1, 0, 700, 0, 2, 0, 0, 639, 0, 0);
    add("e_wrap", 0, 0, 1, 0, 700, 0, 2, 0, 0, 1,   0, 1);
    // lane1: zero step holds, then left wrap
    add("f_load", 1, 1, 0, 0, 50, 1, 0, 0, 0, 50, 1, 0);
    for (int k = 0; k < 3; k++)
      add("f_step0", 1, 0, 1, 0, 50, 1, 0, 0, 0, 50, 1, 0);
    add("f_load2", 1, 1, 0, 0, 3, 1, 7, 0, 0, 3,   1, 0);
    add("f_lwrap", 1, 0, 1, 0, 3, 1, 7, 0, 0, 636, 1, 1);
    // lane0: divider lowered below the running count waits for counter wrap
    add("g_load", 0, 1, 0, 0, 20, 0, 1, 3, 0, 20, 0, 0);
    add("g_t1",   0, 0, 1, 0, 20, 0, 1, 3, 0, 20, 0, 0);
    add("g_t2",   0, 0, 1, 0, 20, 0, 1, 3, 0, 20, 0, 0);
    add("g_t3",   0, 0, 1, 0, 20, 0, 1, 1, 0, 20, 0, 0);
    add("g_t4",   0, 0, 1, 0, 20, 0, 1, 1, 0, 20, 0, 0);
    add("g_t5",   0, 0, 1, 0, 20, 0, 1, 1, 0, 20, 0, 0);
    add("g_t6",   0, 0, 1, 0, 20, 0, 1, 1, 0, 21, 0, 0);

    // reset state
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_all("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(expect_word(vecs[i]));
      @(posedge clk);
      #1;
      check_all(vecs[i].nm, exp_q.pop_front());
    end

    // all lanes hit an edge on the same step
    @(negedge clk);
    idle_inputs();
    load       = 1'b1;
    start_pos  = {4{10'd639}};
    cfg_step   = {4{3'd1}};
    cfg_bounce = 4'b1100;
    exp_q.push_back({{4{10'd639}}, 4'b0000, 4'b0000});
    @(posedge clk);
    #1;
    check_all("m_load", exp_q.pop_front());
    @(negedge clk);
    load = 1'b0;
    move = 1'b1;
    exp_q.push_back({10'd639, 10'd639, 10'd0, 10'd0, 4'b1100, 4'b1111});
    @(posedge clk);
    #1;
    check_all("m_edges", exp_q.pop_front());

    // asynchronous reset mid-motion, observed before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", '0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
